// File: rtl/tile_fill_dma.sv
// tile_fill_dma: fills a rectangle of the square tile map with a tile index by
// issuing one byte-strobed word write per tile to the tile memory window.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// cmd_valid/cmd_ready accepts a command only while idle. mem_valid, once
// raised, holds with stable mem_addr/mem_wdata/mem_wstrb until mem_ready is
// seen; it is never withdrawn early (abort included), only by reset.
module tile_fill_dma #(
  parameter logic [31:0] TILE_BASE = 32'h0520_0000,
  parameter int          MAP_BITS  = 6
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [MAP_BITS-1:0] cmd_x,
  input  logic [MAP_BITS-1:0] cmd_y,
  input  logic [MAP_BITS:0]   cmd_w,
  input  logic [MAP_BITS:0]   cmd_h,
  input  logic [5:0]          cmd_tile,
  input  logic                cmd_incr,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  output logic [1:0]          dbg_state
);

  localparam int PAD = 32 - 2 * MAP_BITS - 2;
  localparam logic [MAP_BITS:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [MAP_BITS-1:0] x0, x0_n, y0, y0_n;
  logic [MAP_BITS:0]   w, w_n, h, h_n;
  logic [MAP_BITS:0]   col, col_n, row, row_n;
  logic [5:0]          tile, tile_n;
  logic                incr, incr_n;
  logic                abort_q, abort_n;
  logic                handshake, last_write;
  logic [MAP_BITS-1:0] col_abs, row_abs;
  logic [31:0]         addr_n;

  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  assign handshake  = mem_valid && mem_ready;
  assign last_write = (col == w - CNT_ONE) && (row == h - CNT_ONE);

  // Next-state and command-context update; abort is sticky only while busy.
  always_comb begin
    state_n = state;
    x0_n    = x0;
    y0_n    = y0;
    w_n     = w;
    h_n     = h;
    col_n   = col;
    row_n   = row;
    tile_n  = tile;
    incr_n  = incr;
    abort_n = abort_q;
    case (state)
      IDLE: begin
        abort_n = 1'b0;
        if (cmd_valid) begin
          x0_n    = cmd_x;
          y0_n    = cmd_y;
          w_n     = cmd_w;
          h_n     = cmd_h;
          tile_n  = cmd_tile;
          incr_n  = cmd_incr;
          col_n   = '0;
          row_n   = '0;
          state_n = (cmd_w == '0 || cmd_h == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (abort) abort_n = 1'b1;
        if (handshake) begin
          if (incr) tile_n = tile + 6'd1;
          if (col == w - CNT_ONE) begin
            col_n = '0;
            row_n = row + CNT_ONE;
          end else begin
            col_n = col + CNT_ONE;
          end
          if (last_write || abort_q || abort) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Address of the write that will be presented next; coordinates wrap at the map edge.
  always_comb begin
    col_abs = x0_n + col_n[MAP_BITS-1:0];
    row_abs = y0_n + row_n[MAP_BITS-1:0];
    addr_n  = TILE_BASE + {{PAD{1'b0}}, row_abs, col_abs, 2'b00};
  end

  // State, command context and registered bus outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      x0        <= '0;
      y0        <= '0;
      w         <= '0;
      h         <= '0;
      col       <= '0;
      row       <= '0;
      tile      <= '0;
      incr      <= 1'b0;
      abort_q   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state     <= state_n;
      x0        <= x0_n;
      y0        <= y0_n;
      w         <= w_n;
      h         <= h_n;
      col       <= col_n;
      row       <= row_n;
      tile      <= tile_n;
      incr      <= incr_n;
      abort_q   <= abort_n;
      mem_valid <= (state_n == ISSUE);
      if (state_n == ISSUE) begin
        mem_addr  <= addr_n;
        mem_wdata <= {26'b0, tile_n};
        mem_wstrb <= 4'b0001;
      end
    end
  end

endmodule

// File: tb/tb_tile_fill_dma.sv
// Directed bench for tile_fill_dma: expected writes are modelled and queued
// when each command is driven, then popped as the DUT completes handshakes.
module tb_tile_fill_dma;

  localparam logic [31:0] BASE = 32'h0520_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic [6:0]  cmd_w = '0;
  logic [6:0]  cmd_h = '0;
  logic [5:0]  cmd_tile = '0;
  logic        cmd_incr = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;

  tile_fill_dma dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_tile  (cmd_tile),
    .cmd_incr  (cmd_incr),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input int x, input int y, input int col, input int row);
    return BASE + 32'(((((y + row) % 64) * 64) + ((x + col) % 64)) * 4);
  endfunction

  // Drives one command from the IDLE state (called at posedge+1), plays the
  // mem_ready pattern and scores every write. Returns at posedge+1, idle.
  task automatic do_cmd(input string name, input int x, input int y, input int w, input int h,
                        input int tile, input bit incr, input int stall_write, input int stall_len,
                        input bit do_abort);
    int n_exp, n_stall_exp, hs, stall_cnt, stall_seen, cyc, done_cyc, exp_done;
    logic [63:0] head;
    n_exp = w * h;
    if (do_abort && stall_write < n_exp) n_exp = stall_write;
    n_stall_exp = (stall_write >= 1 && stall_write <= n_exp) ? stall_len : 0;
    exp_done = n_exp + n_stall_exp + 1;
    exp_q.delete();
    for (int i = 0; i < n_exp; i++) begin
      exp_q.push_back({model_addr(x, y, i % w, i / w), 32'((incr ? tile + i : tile) % 64)});
    end

    check({name, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_x     = x[5:0];
    cmd_y     = y[5:0];
    cmd_w     = w[6:0];
    cmd_h     = h[6:0];
    cmd_tile  = tile[5:0];
    cmd_incr  = incr;
    mem_ready = 1'b1;
    abort     = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;

    hs = 0; stall_cnt = 0; stall_seen = 0; cyc = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 2000) begin
      cyc++;
      if (hs == stall_write - 1 && stall_cnt < stall_len) begin
        mem_ready = 1'b0;
        abort     = do_abort && (stall_cnt == 0);
        stall_cnt++;
      end else begin
        mem_ready = 1'b1;
        abort     = 1'b0;
      end
      @(negedge clk);
      if (mem_valid) begin
        if (mem_ready) begin
          if (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            check({name, "_write"}, {mem_addr, mem_wdata}, head);
          end
          check({name, "_wstrb"}, 64'(mem_wstrb), 64'(4'b0001));
          hs++;
        end else begin
          stall_seen++;
          if (exp_q.size() > 0) check({name, "_stall_hold"}, {mem_addr, mem_wdata}, exp_q[0]);
        end
      end
      if (done) begin
        done_cyc = cyc;
        check({name, "_valid_at_done"}, 64'(mem_valid), 64'(0));
        check({name, "_busy_at_done"}, 64'(busy), 64'(1));
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check({name, "_writes"}, 64'(hs), 64'(n_exp));
    check({name, "_stalls"}, 64'(stall_seen), 64'(n_stall_exp));
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
    abort     = 1'b0;
    mem_ready = 1'b1;
    check({name, "_done_single"}, 64'(done), 64'(0));
    check({name, "_idle_ready"}, 64'(cmd_ready), 64'(1));
    check({name, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    // Reset
    #1;
    check("rst_mem_valid", 64'(mem_valid), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_state", 64'(dbg_state), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Directed commands
    do_cmd("basic", 3, 5, 2, 2, 8'h2A, 1'b0, 0, 0, 1'b0);
    do_cmd("wrap", 63, 63, 2, 2, 7, 1'b0, 0, 0, 1'b0);
    do_cmd("incr", 0, 0, 4, 1, 62, 1'b1, 0, 0, 1'b0);
    do_cmd("backpressure", 7, 9, 2, 2, 5, 1'b1, 2, 3, 1'b0);
    do_cmd("zero_w", 4, 4, 0, 5, 1, 1'b0, 0, 0, 1'b0);
    do_cmd("zero_h", 4, 4, 3, 0, 1, 1'b0, 0, 0, 1'b0);
    do_cmd("abort", 20, 30, 8, 8, 9, 1'b1, 3, 2, 1'b1);

    // Reset in the middle of a fill
    cmd_valid = 1'b1;
    cmd_x = 6'd10; cmd_y = 6'd10; cmd_w = 7'd8; cmd_h = 7'd8;
    cmd_tile = 6'd3; cmd_incr = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_valid_before", 64'(mem_valid), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_valid", 64'(mem_valid), 64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_addr", 64'(mem_addr), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    do_cmd("after_reset", 1, 2, 3, 1, 11, 1'b0, 0, 0, 1'b0);

    // A few random small regions
    for (int k = 0; k < 4; k++) begin
      do_cmd("random", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
             int'($urandom_range(1, 5)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
